// File: rtl/byte_serializer.sv
// byte_serializer: buffers parallel words in a FIFO and shifts each one out MSB-first as a qualified serial stream.
// Optional feature macro: BYTE_SERIALIZER_PARITY_EN appends an even-parity bit after the LSB of every frame.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    word to serialize (DATA_W bits)
//   in_valid   in_data is offered
//   in_ready   word can be accepted (transfer on in_valid && in_ready)
//   flush      synchronous abort, empties FIFO and shifter
//   bit_out    registered serial bit
//   bit_valid  registered qualifier for bit_out
//   busy       shifter is emitting a word
//   level      FIFO occupancy, 0..DEPTH, shifter excluded
module byte_serializer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     bit_out,
    output logic                     bit_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
`ifdef BYTE_SERIALIZER_PARITY_EN
    localparam int LAST = DATA_W;
`else
    localparam int LAST = DATA_W - 1;
`endif
    localparam int CW = $clog2(LAST + 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [PW-1:0]     r_level;
    logic [DATA_W-1:0] r_shift;
    logic [CW-1:0]     r_cnt;
    logic              r_bit_out;
    logic              r_bit_valid;
`ifdef BYTE_SERIALIZER_PARITY_EN
    logic              r_par;
`endif
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_last;
    logic              w_shifting;
    logic              w_next_bit;
    logic [DATA_W-1:0] w_head;
    logic              w_bit_out_nxt;
    logic              w_bit_valid_nxt;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_empty    = r_wp == r_rp;
    assign w_full     = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign in_ready   = !w_full && !flush;
    assign w_push     = in_valid && in_ready;
    assign w_head     = r_mem[r_rp[AW-1:0]];
    assign w_last     = r_cnt == CW'(LAST);
    assign w_shifting = (r_state == S_SHIFT) && !w_last;
    // Popping on the last slot of a frame is what keeps consecutive frames gapless.
    assign w_pop      = !flush && !w_empty && ((r_state == S_IDLE) || w_last);

    // The shift register rotates left, so the bit after the current one sits just below the MSB.
`ifdef BYTE_SERIALIZER_PARITY_EN
    assign w_next_bit = (r_cnt == CW'(DATA_W - 1)) ? r_par : r_shift[DATA_W-2];
`else
    assign w_next_bit = r_shift[DATA_W-2];
`endif

    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign busy      = r_state == S_SHIFT;
    assign level     = r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_out   <= w_bit_out_nxt;
            r_bit_valid <= w_bit_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = flush ? S_IDLE : w_pop ? S_SHIFT : w_last ? S_IDLE : r_state;
    end

    always_comb begin
        w_bit_valid_nxt = w_state_nxt == S_SHIFT;
        w_bit_out_nxt   = flush ? 1'b0 : w_pop ? w_head[DATA_W-1] : w_shifting ? w_next_bit : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
`ifdef BYTE_SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            r_wp    <= r_wp + PW'(w_push);
            r_rp    <= r_rp + PW'(w_pop);
            r_level <= r_level + PW'(w_push) - PW'(w_pop);
            if (w_pop) begin
                r_shift <= w_head;
                r_cnt   <= '0;
`ifdef BYTE_SERIALIZER_PARITY_EN
                r_par   <= ^w_head;
`endif
            end else if (w_shifting) begin
                r_shift <= {r_shift[DATA_W-2:0], r_shift[DATA_W-1]};
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: scoreboard bench for byte_serializer (DATA_W=8, DEPTH=4).
module tb_byte_serializer;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
`ifdef BYTE_SERIALIZER_PARITY_EN
    localparam int FL = DW + 1;
`else
    localparam int FL = DW;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          in_ready;
    logic          bit_out;
    logic          bit_valid;
    logic          busy;
    logic [2:0]    level;

    always #5 clk = ~clk;

    byte_serializer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy), .level(level)
    );

    int   vecs = 0;
    int   errs = 0;
    int   cyc = 0;
    int   first = -1;
    int   last = -1;
    int   busy_mis = 0;
    logic obs_q[$];
    logic exp_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bit_valid === 1'b1) begin
            obs_q.push_back(bit_out);
            if (first < 0) first = cyc;
            last = cyc;
        end
        if (busy !== bit_valid) busy_mis++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear();
        obs_q.delete();
        exp_q.delete();
        first = -1;
        last = -1;
        busy_mis = 0;
    endtask

    task automatic add_exp(input logic [DW-1:0] d);
        for (int i = DW - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef BYTE_SERIALIZER_PARITY_EN
        exp_q.push_back(^d);
`endif
    endtask

    // Offers d until accepted; acc is the edge index of the transfer, -1 on timeout.
    task automatic push(input logic [DW-1:0] d, output int acc);
        logic r;
        in_valid = 1'b1;
        in_data = d;
        acc = -1;
        for (int k = 0; k < 200 && acc < 0; k++) begin
            #1;
            r = in_ready;
            step();
            if (r) acc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run(2);
        vecs++; if (bit_out !== 1'b0) begin errs++; $display("FAIL reset_bit_out: got %b want 0", bit_out); end
        vecs++; if (bit_valid !== 1'b0) begin errs++; $display("FAIL reset_bit_valid: got %b want 0", bit_valid); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        vecs++; if (level !== 3'd0) begin errs++; $display("FAIL reset_level: got %0d want 0", level); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int a;
        int n;
        logic e;
        logic o;
        clear();
        add_exp(8'hD0);
        push(8'hD0, a);
        run(FL + 4);
        vecs++; if (first !== a + 1) begin errs++; $display("FAIL single_latency: got %0d want %0d", first, a + 1); end
        vecs++; if (last - first + 1 !== FL) begin errs++; $display("FAIL single_span: got %0d want %0d", last - first + 1, FL); end
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            vecs++; if (o !== e) begin errs++; $display("FAIL single_bit%0d: got %b want %b", n, o, e); end
            n++;
        end
        vecs++; if (obs_q.size() != 0) begin errs++; $display("FAIL single_extra: got %0d extra bits want 0", obs_q.size()); end
        vecs++; if (bit_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL single_idle: got valid=%b busy=%b want 0 0", bit_valid, busy); end
        vecs++; if (busy_mis != 0) begin errs++; $display("FAIL single_busy: got %0d busy/valid disagreements want 0", busy_mis); end
    endtask

    task automatic test_back_to_back();
        int a;
        int b;
        int n;
        logic e;
        logic o;
        clear();
        add_exp(8'hB4);
        add_exp(8'h0D);
        push(8'hB4, a);
        vecs++; if (level !== 3'd1) begin errs++; $display("FAIL b2b_level0: got %0d want 1", level); end
        push(8'h0D, b);
        vecs++; if (b !== a + 1) begin errs++; $display("FAIL b2b_accept: got %0d want %0d", b, a + 1); end
        vecs++; if (level !== 3'd1) begin errs++; $display("FAIL b2b_level1: got %0d want 1", level); end
        run(FL - 1);
        vecs++; if (level !== 3'd1) begin errs++; $display("FAIL b2b_level2: got %0d want 1", level); end
        step();
        vecs++; if (level !== 3'd0) begin errs++; $display("FAIL b2b_level3: got %0d want 0", level); end
        run(FL + 4);
        vecs++; if (first !== a + 1) begin errs++; $display("FAIL b2b_latency: got %0d want %0d", first, a + 1); end
        vecs++; if (last - first + 1 !== 2 * FL) begin errs++; $display("FAIL b2b_span: got %0d want %0d", last - first + 1, 2 * FL); end
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            vecs++; if (o !== e) begin errs++; $display("FAIL b2b_bit%0d: got %b want %b", n, o, e); end
            n++;
        end
        vecs++; if (obs_q.size() != 0) begin errs++; $display("FAIL b2b_extra: got %0d extra bits want 0", obs_q.size()); end
        vecs++; if (busy_mis != 0) begin errs++; $display("FAIL b2b_busy: got %0d busy/valid disagreements want 0", busy_mis); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] words [6];
        int a0;
        int a;
        int n;
        logic e;
        logic o;
        words = '{8'h3C, 8'hA5, 8'h71, 8'hE2, 8'h19, 8'hC6};
        clear();
        for (int i = 0; i < 5; i++) begin
            add_exp(words[i]);
            push(words[i], a);
            if (i == 0) a0 = a;
        end
        vecs++; if (a !== a0 + 4) begin errs++; $display("FAIL bp_fill: got %0d want %0d", a, a0 + 4); end
        vecs++; if (level !== 3'd4) begin errs++; $display("FAIL bp_level_full: got %0d want 4", level); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
        add_exp(words[5]);
        push(words[5], a);
        vecs++; if (a !== a0 + FL + 2) begin errs++; $display("FAIL bp_reaccept: got %0d want %0d", a, a0 + FL + 2); end
        run(6 * FL + 6);
        vecs++; if (first !== a0 + 1) begin errs++; $display("FAIL bp_latency: got %0d want %0d", first, a0 + 1); end
        vecs++; if (last - first + 1 !== 6 * FL) begin errs++; $display("FAIL bp_span: got %0d want %0d", last - first + 1, 6 * FL); end
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            vecs++; if (o !== e) begin errs++; $display("FAIL bp_bit%0d: got %b want %b", n, o, e); end
            n++;
        end
        vecs++; if (obs_q.size() != 0) begin errs++; $display("FAIL bp_extra: got %0d extra bits want 0", obs_q.size()); end
        vecs++; if (level !== 3'd0) begin errs++; $display("FAIL bp_drained: got %0d want 0", level); end
    endtask

    task automatic test_flush();
        int a;
        int n;
        logic e;
        logic o;
        clear();
        push(8'hFF, a);
        push(8'h0F, a);
        push(8'hAA, a);
        step();
        for (int i = 0; i < 3; i++) exp_q.push_back(1'b1);
        flush = 1'b1;
        #1;
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        step();
        flush = 1'b0;
        vecs++; if (bit_valid !== 1'b0) begin errs++; $display("FAIL flush_valid: got %b want 0", bit_valid); end
        vecs++; if (bit_out !== 1'b0) begin errs++; $display("FAIL flush_bit_out: got %b want 0", bit_out); end
        vecs++; if (level !== 3'd0) begin errs++; $display("FAIL flush_level: got %0d want 0", level); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL flush_busy: got %b want 0", busy); end
        add_exp(8'h81);
        push(8'h81, a);
        run(FL + 4);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            vecs++; if (o !== e) begin errs++; $display("FAIL flush_bit%0d: got %b want %b", n, o, e); end
            n++;
        end
        vecs++; if (obs_q.size() != 0) begin errs++; $display("FAIL flush_extra: got %0d extra bits want 0", obs_q.size()); end
    endtask

    task automatic test_reset_mid();
        int a;
        int n;
        logic e;
        logic o;
        clear();
        push(8'hE5, a);
        push(8'h3C, a);
        push(8'h96, a);
        vecs++; if (level !== 3'd2) begin errs++; $display("FAIL rstmid_level_pre: got %0d want 2", level); end
        step();
        for (int i = 0; i < 3; i++) exp_q.push_back(1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        vecs++; if (bit_out !== 1'b0) begin errs++; $display("FAIL rstmid_bit_out: got %b want 0", bit_out); end
        vecs++; if (bit_valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid: got %b want 0", bit_valid); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        vecs++; if (level !== 3'd0) begin errs++; $display("FAIL rstmid_level: got %0d want 0", level); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        run(FL + 6);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            vecs++; if (o !== e) begin errs++; $display("FAIL rstmid_bit%0d: got %b want %b", n, o, e); end
            n++;
        end
        vecs++; if (obs_q.size() != 0) begin errs++; $display("FAIL rstmid_stale: got %0d extra bits want 0", obs_q.size()); end
    endtask

`ifdef BYTE_SERIALIZER_PARITY_EN
    task automatic test_parity();
        int a;
        int b;
        int n;
        logic e;
        logic o;
        clear();
        for (int i = 7; i >= 0; i--) exp_q.push_back(i == 7 || i == 6 || i == 4);
        exp_q.push_back(1'b1);
        for (int i = 7; i >= 0; i--) exp_q.push_back(i == 0);
        exp_q.push_back(1'b1);
        push(8'hD0, a);
        push(8'h01, b);
        run(2 * FL + 4);
        vecs++; if (last - first + 1 !== 18) begin errs++; $display("FAIL parity_span: got %0d want 18", last - first + 1); end
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            vecs++; if (o !== e) begin errs++; $display("FAIL parity_bit%0d: got %b want %b", n, o, e); end
            n++;
        end
        vecs++; if (obs_q.size() != 0) begin errs++; $display("FAIL parity_extra: got %0d extra bits want 0", obs_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
`ifdef BYTE_SERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/byte_serializer.md
# byte_serializer

Upstream feeder for the serial pattern-detector stage. It accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. It then shifts each word out MSB-first, one bit per clock, as a qualified serial stream (`bit_out`/`bit_valid`) that drives the detector's serial input. Back-to-back words stream with no idle gap between them.

## Interface
Parameters:
- `DATA_W`, default 8: word width, range ≥ 2.
- `DEPTH`, default 4: FIFO entries, a power of two, ≥ 2.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_data`, input, `DATA_W`: word to serialize.
- `in_valid`, input, 1: `in_data` is offered.
- `in_ready`, output, 1: block can accept. Transfer occurs on a clock edge where `in_valid && in_ready`.
- `flush`, input, 1: synchronous abort; empties FIFO and shifter.
- `bit_out`, output, 1: serial bit, registered.
- `bit_valid`, output, 1: `bit_out` is a real data bit, registered.
- `busy`, output, 1: shifter holds a word being emitted.
- `level`, output, `$clog2(DEPTH)+1`: FIFO occupancy, 0..`DEPTH`; excludes the shifter.

## Operation
- FIFO is a circular buffer with write/read pointers one bit wider than the index. `full` is defined as `level == DEPTH`; `empty` as `level == 0`.
- `in_ready = !full && !flush`, combinational. Pushes are always accepted into the FIFO, never directly into the shifter.
- The shifter FSM has two states:
  - **IDLE**: `bit_valid`=0 and `bit_out`=0. If FIFO is not empty, pop the head word into the shift register, set bit counter to 0, go to SHIFT.
  - **SHIFT**: each cycle present word bit `DATA_W-1-cnt` with `bit_valid`=1.
    - On the last bit (`cnt == DATA_W-1`, or the parity slot when enabled): if FIFO is not empty, pop the next word and stay in SHIFT with `cnt`=0. This is the gapless path. Otherwise go to IDLE.
- Simultaneous push and pop in one cycle: `level` is unchanged and both pointers advance. When full, a push is blocked even if a pop happens in the same cycle (no pass-through).
- `flush` has priority over push, pop and shift:
  - next cycle: `level`=0, FSM=IDLE, `bit_valid`=0, `bit_out`=0;
  - any partially emitted word is discarded.
- `rst` has priority over everything. Reset values: `bit_out`=0, `bit_valid`=0, `busy`=0, `level`=0, FSM=IDLE, pointers=0. `in_ready`=1 in the first cycle after reset.
- Reset or flush mid-word truncates the serial frame. The downstream detector sees `bit_valid` drop and handles it as a gap.

## Timing
- A word accepted at edge N is popped at edge N+1 if the shifter is idle. Its MSB appears on `bit_out`/`bit_valid` in the cycle following edge N+1, i.e. 2 cycles of latency.
- A frame occupies exactly `DATA_W` consecutive `bit_valid` cycles, or `DATA_W+1` with parity enabled.
- Sustained throughput is one word per `DATA_W` cycles, with zero idle cycles between words while the FIFO is non-empty.
- `busy` is high in exactly the cycles where `bit_valid` is high.
- `level` updates on the edge of the push/pop and is registered.

## Configuration
- Macro `BYTE_SERIALIZER_PARITY_EN`:
  - **Defined**: each frame appends one even-parity bit (XOR of all `DATA_W` data bits) after the LSB, with `bit_valid`=1, so frame length is `DATA_W+1`. The gapless pop happens on the parity slot.
  - **Undefined**: no parity slot; frame length is `DATA_W`. Counter width is sized accordingly.

## Test plan
Defaults are `DATA_W`=8 and `DEPTH`=4.
1. **Single word.** After reset, push 0xD0 once.
   - `bit_out` = 1,1,0,1,0,0,0,0 with `bit_valid`=1 on 8 consecutive cycles, starting 2 cycles after acceptance.
   - Then `bit_valid`=0 and `busy`=0.
2. **Back-to-back.** Push 0xB4 and 0x0D on consecutive cycles.
   - 16 consecutive valid bits: 10110100 00001101, no gap.
   - `level` sequence is 1,1,0 around the pops.
3. **Backpressure.** Hold `in_valid`=1 with 6 distinct words.
   - `in_ready` falls when `level`=4, one word being in the shifter.
   - It rises again one cycle after each pop.
   - All 6 words emerge in order; none is lost or duplicated.
4. **Flush mid-frame.** Push 0xFF, 0x0F and 0xAA, then assert `flush` after 3 bits of 0xFF.
   - Next cycle: `bit_valid`=0 and `level`=0.
   - A push of 0x81 afterwards emits 10000001 only.
5. **Reset mid-operation.** Assert `rst` for 1 cycle while the FIFO holds 2 words and a frame is mid-shift.
   - All outputs take their reset values next cycle; no stale bits follow.
   - `in_ready`=1.
6. **Parity** (`BYTE_SERIALIZER_PARITY_EN` defined). Push 0xD0 then 0x01.
   - Frames are 11010000+1 and 00000001+1: 18 consecutive valid bits, no gap.
